// File: rtl/calculadora_seq_if.sv
// Bus between a requester and the sequential calculator: operands, opcode,
// request strobe, registered result and status flags.
interface calculadora_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] entrada_A;
    logic [WIDTH-1:0] entrada_B;
    logic [2:0]       codigo;
    logic             valido;
    logic [WIDTH-1:0] saida;
    logic             pronto;
    logic             ocupado;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             erro;

    // Requester side
    modport master (
        output entrada_A, entrada_B, codigo, valido,
        input  saida, pronto, ocupado, carry, overflow, zero, erro
    );

    // Calculator side
    modport slave (
        input  entrada_A, entrada_B, codigo, valido,
        output saida, pronto, ocupado, carry, overflow, zero, erro
    );
endinterface

// File: rtl/calculadora_seq.sv
// Sequential calculator: single-cycle ops complete on the acceptance edge,
// multiply runs a WIDTH-cycle shift-add. Three states: OCIOSO, MULT, FIM.
module calculadora_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    calculadora_seq_if.slave     bus
);
    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] MULT   = 2'd1;
    localparam logic [1:0] FIM    = 2'd2;

    localparam logic [2:0] OP_ZERAR = 3'b000;
    localparam logic [2:0] OP_MOSTA = 3'b001;
    localparam logic [2:0] OP_MOSTB = 3'b010;
    localparam logic [2:0] OP_SOMAR = 3'b011;
    localparam logic [2:0] OP_SUBTR = 3'b100;
    localparam logic [2:0] OP_MULT  = 3'b101;
    localparam logic [2:0] OP_ACUM  = 3'b110;

    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         r_estado;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [2:0]         r_codigo;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_saida;
    logic               r_carry;
    logic               r_overflow;
    logic               r_zero;
    logic               r_erro;

    logic               w_aceita;
    logic               w_ultimo;
    logic               w_fim;
    logic [2:0]         w_code;
    logic [WIDTH:0]     w_soma;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH:0]     w_acum;
    logic [2*WIDTH-1:0] w_parcial;
    logic [2*WIDTH-1:0] w_prod_prox;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic               w_erro;

    assign w_aceita = bus.valido && (r_estado == OCIOSO);
    assign w_ultimo = (r_estado == MULT) && (r_cnt == CW'(WIDTH - 1));
    assign w_fim    = (w_aceita && (bus.codigo != OP_MULT)) || w_ultimo;

    // During MULT the decode must see the latched opcode, not the live bus
    assign w_code = (r_estado == MULT) ? r_codigo : bus.codigo;

    assign w_soma = {1'b0, bus.entrada_A} + {1'b0, bus.entrada_B};
    assign w_dif  = {1'b0, bus.entrada_A} - {1'b0, bus.entrada_B};
    assign w_acum = {1'b0, r_saida} + {1'b0, bus.entrada_A};

    // One shift-add step: add A<<cnt when bit cnt of B is set
    assign w_parcial   = {{WIDTH{1'b0}}, r_op_a} << r_cnt;
    assign w_prod_prox = r_prod + (r_op_b[r_cnt] ? w_parcial : '0);

    // Result and flag decode for whichever operation completes this cycle
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_erro  = 1'b0;
        case (w_code)
            OP_ZERAR: w_res = '0;
            OP_MOSTA: w_res = bus.entrada_A;
            OP_MOSTB: w_res = bus.entrada_B;
            OP_SOMAR: begin
                w_res   = w_soma[MSB:0];
                w_carry = w_soma[WIDTH];
                w_ovf   = (bus.entrada_A[MSB] == bus.entrada_B[MSB]) &&
                          (w_soma[MSB] != bus.entrada_A[MSB]);
            end
            OP_SUBTR: begin
                w_res   = w_dif[MSB:0];
                w_carry = w_dif[WIDTH];
                w_ovf   = (bus.entrada_A[MSB] != bus.entrada_B[MSB]) &&
                          (w_dif[MSB] != bus.entrada_A[MSB]);
            end
            OP_MULT: begin
                w_res = w_prod_prox[MSB:0];
                w_ovf = |w_prod_prox[2*WIDTH-1:WIDTH];
            end
            OP_ACUM: begin
                w_res   = w_acum[MSB:0];
                w_carry = w_acum[WIDTH];
                w_ovf   = (r_saida[MSB] == bus.entrada_A[MSB]) &&
                          (w_acum[MSB] != r_saida[MSB]);
            end
            default: begin
                w_res  = '0;
                w_erro = 1'b1;
            end
        endcase
    end

    // Control FSM, operand latches and multiply datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_codigo <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (bus.valido) begin
                        r_op_a   <= bus.entrada_A;
                        r_op_b   <= bus.entrada_B;
                        r_codigo <= bus.codigo;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_estado <= (bus.codigo == OP_MULT) ? MULT : FIM;
                    end
                end
                MULT: begin
                    r_prod <= w_prod_prox;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_ultimo) begin
                        r_estado <= FIM;
                    end
                end
                FIM:     r_estado <= OCIOSO;
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    // Result and flags: written only at completion edges, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_saida    <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_erro     <= 1'b0;
        end else if (w_fim) begin
            r_saida    <= w_res;
            r_carry    <= w_carry;
            r_overflow <= w_ovf;
            r_zero     <= (w_res == '0);
            r_erro     <= w_erro;
        end
    end

    assign bus.saida    = r_saida;
    assign bus.pronto   = (r_estado == FIM);
    assign bus.ocupado  = (r_estado != OCIOSO);
    assign bus.carry    = r_carry;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;
    assign bus.erro     = r_erro;
endmodule

// File: tb/tb_calculadora_seq.sv
// Scoreboard bench for calculadora_seq at WIDTH=8.
module tb_calculadora_seq;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   m_saida;

    typedef struct {
        int saida;
        int c;
        int o;
        int z;
        int e;
        int lat;
    } exp_t;

    exp_t sb_q[$];

    calculadora_seq_if #(.WIDTH(WIDTH)) bus ();

    calculadora_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference model for one operation, using the current model saida
    function automatic exp_t model(input int c, input int a, input int b, input int acc);
        exp_t e;
        int   r;
        int   s;
        e.c = 0; e.o = 0; e.e = 0; e.lat = 1;
        r = 0;
        case (c)
            0: r = 0;
            1: r = a;
            2: r = b;
            3: begin
                r = a + b; e.c = (r > 255) ? 1 : 0;
                s = sx(a) + sx(b); e.o = (s > 127 || s < -128) ? 1 : 0;
            end
            4: begin
                r = a - b + 256; e.c = (a < b) ? 1 : 0;
                s = sx(a) - sx(b); e.o = (s > 127 || s < -128) ? 1 : 0;
            end
            5: begin
                r = a * b; e.o = (r > 255) ? 1 : 0; e.lat = WIDTH + 1;
            end
            6: begin
                r = acc + a; e.c = (r > 255) ? 1 : 0;
                s = sx(acc) + sx(a); e.o = (s > 127 || s < -128) ? 1 : 0;
            end
            default: begin r = 0; e.e = 1; end
        endcase
        e.saida = r % 256;
        e.z = (e.saida == 0) ? 1 : 0;
        return e;
    endfunction

    // Issue one request in the current cycle, wait for pronto, score it.
    // poke drives a stray somar request in cycle N+3 that must be ignored.
    task automatic do_op(input int c, input int a, input int b, input bit poke);
        exp_t e;
        exp_t g;
        int   lat;
        bit   seen;
        int   held;
        check_eq("idle_before_req", bus.ocupado, 0);
        e = model(c, a, b, m_saida);
        m_saida = e.saida;
        sb_q.push_back(e);
        bus.entrada_A = a[7:0];
        bus.entrada_B = b[7:0];
        bus.codigo    = c[2:0];
        bus.valido    = 1'b1;
        @(negedge clk);
        bus.valido = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 40) begin
            if (bus.pronto) begin
                seen = 1'b1;
            end else begin
                check_eq("busy_while_running", bus.ocupado, 1);
                if (poke && lat == 3) begin
                    bus.entrada_A = 8'd1;
                    bus.entrada_B = 8'd1;
                    bus.codigo    = 3'b011;
                    bus.valido    = 1'b1;
                end
                @(negedge clk);
                bus.valido = 1'b0;
                lat++;
            end
        end
        g = sb_q.pop_front();
        check_eq("pronto_latency", seen ? lat : -1, g.lat);
        check_eq("saida", bus.saida, g.saida);
        check_eq("carry", bus.carry, g.c);
        check_eq("overflow", bus.overflow, g.o);
        check_eq("zero", bus.zero, g.z);
        check_eq("erro", bus.erro, g.e);
        check_eq("busy_in_fim", bus.ocupado, 1);
        held = bus.saida;
        @(negedge clk);
        check_eq("pronto_one_cycle", bus.pronto, 0);
        check_eq("idle_after_fim", bus.ocupado, 0);
        check_eq("saida_holds", bus.saida, held);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_saida  = 0;
        bus.entrada_A = '0;
        bus.entrada_B = '0;
        bus.codigo    = '0;
        bus.valido    = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        // Request during reset must be dropped
        bus.valido = 1'b1;
        bus.codigo = 3'b001;
        bus.entrada_A = 8'd55;
        @(negedge clk);
        bus.valido = 1'b0;
        check_eq("rst_saida", bus.saida, 0);
        check_eq("rst_flags", {bus.carry, bus.overflow, bus.zero, bus.erro}, 0);
        check_eq("rst_pronto", bus.pronto, 0);
        check_eq("rst_ocupado", bus.ocupado, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ocupado", bus.ocupado, 0);

        do_op(3, 200, 100, 1'b0);
        do_op(4, 5, 10, 1'b0);
        do_op(4, 128, 1, 1'b0);
        do_op(5, 20, 13, 1'b1);
        do_op(5, 255, 255, 1'b0);
        do_op(5, 3, 0, 1'b0);
        do_op(0, 9, 9, 1'b0);
        do_op(6, 100, 0, 1'b0);
        do_op(6, 100, 0, 1'b0);
        do_op(6, 100, 0, 1'b0);
        do_op(7, 7, 0, 1'b0);
        do_op(1, 7, 0, 1'b0);
        do_op(2, 0, 33, 1'b0);
        do_op(3, 127, 1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), 1'b0);
        end

        // Reset in cycle N+4 of a multiply: no pronto, immediate recovery
        bus.entrada_A = 8'd20;
        bus.entrada_B = 8'd13;
        bus.codigo    = 3'b101;
        bus.valido    = 1'b1;
        @(negedge clk);
        bus.valido = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check_eq("abort_no_pronto", bus.pronto, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        check_eq("abort_no_pronto", bus.pronto, 0);
        @(negedge clk);
        rst = 1'b0;
        m_saida = 0;
        check_eq("abort_saida", bus.saida, 0);
        check_eq("abort_pronto", bus.pronto, 0);
        check_eq("abort_ocupado", bus.ocupado, 0);
        do_op(1, 9, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
